tmr_codec: RTL and testbench
============================

// Module: tmr_codec
// PURPOSE
// - Triple-modular-redundancy codec for power/fault-tolerance evaluation of a 16-bit data path.
// - Encodes a data word into three identical copies and applies an externally supplied
//   fault-injection mask to the 48-bit codeword.
// - Recovers the word by per-bit majority vote.
// - Standalone datapath block driven by a stimulus/fault-injection harness; no handshake.
// PARAMETERS
// - DATA_W  16  width of the protected data word; codeword width is 3*DATA_W (copy count fixed at 3)
// PORTS
// - clk           input   1         single clock; all state updates on posedge
// - rst_n         input   1         synchronous reset, active-low
// - data_in       input   DATA_W    word to protect
// - bit_flip      input   3*DATA_W  fault mask; 1 = invert that codeword bit
// - data_out      output  DATA_W    majority-voted, corrected word
// - err_detected  output  1         1 = at least one copy disagreed with the vote for this word
// BEHAVIOUR
// - Codeword layout: copy0 = [DATA_W-1:0], copy1 = [2*DATA_W-1:DATA_W], copy2 = [3*DATA_W-1:2*DATA_W].
// - Stage 1 (encode), posedge clk: cw_q <= {data_in, data_in, data_in}.
// - Fault injection is combinational on the registered codeword: cw_f = cw_q ^ bit_flip.
//   bit_flip is sampled at the stage-2 edge, not the stage-1 edge.
// - Stage 2 (vote), posedge clk. For each bit i, with a=cw_f[i], b=cw_f[DATA_W+i], c=cw_f[2*DATA_W+i]:
//   - data_out[i] <= (a&b)|(a&c)|(b&c)
//   - err_detected <= OR over i of ~(a==b && b==c)
// - Latency: data_in captured at edge N appears on data_out after edge N+1.
//   Throughput: 1 word/cycle; new data_in accepted every cycle.
// - Reset (rst_n=0 at posedge): cw_q <= 0, data_out <= 0, err_detected <= 0.
//   During reset, bit_flip is ignored by all registers.
//   First valid output follows 2 edges after rst_n is released.
// - Correction capability:
//   - Any flips confined to one copy per bit position are corrected.
//   - Flips in different copies at different bit positions are also corrected.
// - Two or three flips at the same bit position produce a wrong output bit; not flagged beyond err_detected.
//   - 2 flips at the same position: err_detected=1.
//   - 3 flips at the same position with no other disagreement: err_detected=0 (undetectable).
// - No X propagation: outputs depend only on registered state and current bit_flip.
// - No other state or FSM.
// TESTING
// - Reset: rst_n=0 for 2 cycles, data_in=16'hFFFF -> data_out=16'h0000, err_detected=0.
// - Clean path: data_in=16'hA5C3, bit_flip=0 -> data_out=16'hA5C3 two edges later, err_detected=0.
// - Single fault: data_in=16'h1234, bit_flip=48'h0000_0001_0000 (copy1 bit0)
//   -> data_out=16'h1234, err_detected=1.
// - Spread faults: data_in=16'h00FF, bit_flip = copy0 bit3 | copy1 bit7 | copy2 bit15
//   -> data_out=16'h00FF, err_detected=1.
// - Double fault, same position: data_in=16'h0000, bit_flip = copy0 bit5 | copy2 bit5
//   -> data_out=16'h0020, err_detected=1.
// - Random: each cycle random data_in plus one-hot bit_flip over 48 positions
//   -> data_out always equals data_in delayed 2 edges; err_detected=1.

Source files
------------

// File: rtl/tmr_codec_if.sv
// Stimulus/fault-injection bus for the TMR codec: word in, fault mask in, voted word and error flag out.
interface tmr_codec_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0]   data_in;
    logic [3*DATA_W-1:0] bit_flip;
    logic [DATA_W-1:0]   data_out;
    logic                err_detected;

    // Harness side drives the word and fault mask.
    modport master (
        output data_in,
        output bit_flip,
        input  data_out,
        input  err_detected
    );

    // Codec side consumes the word and fault mask.
    modport slave (
        input  data_in,
        input  bit_flip,
        output data_out,
        output err_detected
    );
endinterface

// File: rtl/tmr_codec.sv
// Triple-modular-redundancy codec: triplicate, inject faults, majority-vote back to one word.
module tmr_codec #(
    parameter int unsigned DATA_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    tmr_codec_if.slave  bus
);
    localparam int unsigned CW_W = 3 * DATA_W;

    logic [CW_W-1:0]   cw_q;
    logic [CW_W-1:0]   cw_d;
    logic [CW_W-1:0]   cw_f_c;
    logic [DATA_W-1:0] copy0_c;
    logic [DATA_W-1:0] copy1_c;
    logic [DATA_W-1:0] copy2_c;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              err_q;
    logic              err_d;

    // Encode: three identical copies of the incoming word.
    always_comb begin
        cw_d = {bus.data_in, bus.data_in, bus.data_in};
    end

    // Stage 1 register holding the clean codeword.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cw_q <= '0;
        end else begin
            cw_q <= cw_d;
        end
    end

    // Fault injection on the registered codeword, then per-bit majority vote and disagreement check.
    always_comb begin
        cw_f_c  = cw_q ^ bus.bit_flip;
        copy0_c = cw_f_c[DATA_W-1:0];
        copy1_c = cw_f_c[2*DATA_W-1:DATA_W];
        copy2_c = cw_f_c[3*DATA_W-1:2*DATA_W];
        data_d  = (copy0_c & copy1_c) | (copy0_c & copy2_c) | (copy1_c & copy2_c);
        err_d   = |((copy0_c ^ copy1_c) | (copy1_c ^ copy2_c));
    end

    // Stage 2 register holding the voted word and error flag; reset masks any fault input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.err_detected = err_q;
endmodule

// File: tb/tb_tmr_codec.sv
// Directed and randomized self-checking bench for tmr_codec.
module tb_tmr_codec;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CW_W   = 3 * DATA_W;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tmr_codec_if #(.DATA_W(DATA_W)) bus ();

    tmr_codec #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Capture a word at one edge, apply the fault mask for the vote edge, check the result.
    task automatic run_word(input string tag, input logic [DATA_W-1:0] word, input logic [CW_W-1:0] mask,
                            input logic [DATA_W-1:0] exp_data, input logic exp_err);
        bus.data_in  = word;
        bus.bit_flip = '0;
        tick();
        bus.data_in  = ~word;
        bus.bit_flip = mask;
        tick();
        check_word({tag, "_data"}, bus.data_out, exp_data);
        check_bit({tag, "_err"}, bus.err_detected, exp_err);
        bus.bit_flip = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] prev;
        logic [DATA_W-1:0] cur;
        logic [CW_W-1:0]   one_hot;
        logic [CW_W-1:0]   unit;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.data_in  = 16'hFFFF;
        bus.bit_flip = '1;

        // Reset held two cycles with a live word and all-ones fault mask.
        tick();
        tick();
        check_word("reset_data", bus.data_out, 16'h0000);
        check_bit("reset_err", bus.err_detected, 1'b0);

        rst_n        = 1'b1;
        bus.bit_flip = '0;

        run_word("clean",    16'hA5C3, 48'h0000_0000_0000, 16'hA5C3, 1'b0);
        run_word("single",   16'h1234, 48'h0000_0001_0000, 16'h1234, 1'b1);
        run_word("spread",   16'h00FF, 48'h8000_0080_0008, 16'h00FF, 1'b1);
        run_word("double",   16'h0000, 48'h0020_0000_0020, 16'h0020, 1'b1);
        run_word("triple",   16'h0000, 48'h0001_0001_0001, 16'h0001, 1'b0);
        run_word("copy2all", 16'h5A5A, 48'hFFFF_0000_0000, 16'h5A5A, 1'b1);
        run_word("copy0all", 16'hC3C3, 48'h0000_0000_FFFF, 16'hC3C3, 1'b1);
        run_word("dbl_msb",  16'hFFFF, 48'h8000_8000_0000, 16'h7FFF, 1'b1);

        // Mid-stream reset with a fault mask present clears both outputs.
        rst_n        = 1'b0;
        bus.data_in  = 16'hBEEF;
        bus.bit_flip = 48'h0000_FFFF_FFFF;
        tick();
        check_word("midrst_data", bus.data_out, 16'h0000);
        check_bit("midrst_err", bus.err_detected, 1'b0);
        rst_n        = 1'b1;
        bus.bit_flip = '0;

        // Streaming: a new word every cycle, one-hot fault on the word being voted.
        unit         = 48'h0000_0000_0001;
        prev         = 16'(($urandom));
        bus.data_in  = prev;
        bus.bit_flip = '0;
        tick();
        for (int i = 0; i < 40; i++) begin
            cur          = 16'($urandom);
            one_hot      = unit << $urandom_range(0, CW_W - 1);
            bus.data_in  = cur;
            bus.bit_flip = one_hot;
            tick();
            check_word("rand_data", bus.data_out, prev);
            check_bit("rand_err", bus.err_detected, 1'b1);
            prev = cur;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
